// File: rtl/arp_table_pkg.sv
// rtl/arp_table_pkg.sv - shared state encoding, entry layout and width constants for the ARP lookup.
package arp_table_pkg;

   localparam int IP_WIDTH    = 32;
   localparam int MAC_WIDTH   = 48;
   localparam int ENTRY_WIDTH = 1 + IP_WIDTH + MAC_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   typedef struct packed {
      logic                 valid;
      logic [IP_WIDTH-1:0]  ip;
      logic [MAC_WIDTH-1:0] mac;
   } arp_entry_t;

endpackage

// File: rtl/arp_table_mem.sv
// rtl/arp_table_mem.sv - ARP entry storage with a single host write port.
// All entries are exposed flat so the search logic can use one or all of them per cycle.
module arp_table_mem
   import arp_table_pkg::*;
#(
   parameter int NUM_ENTRIES = 32,
   parameter int IDX_WIDTH   = 5
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_en,
   input  logic [IDX_WIDTH-1:0]               wr_idx,
   input  logic [IP_WIDTH-1:0]                wr_ip,
   input  logic [MAC_WIDTH-1:0]               wr_mac,
   input  logic                               wr_valid,
   output logic [NUM_ENTRIES*ENTRY_WIDTH-1:0] entries_flat
);

   arp_entry_t entries [NUM_ENTRIES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries[i] <= '0;
         end
      end else if (wr_en) begin
         entries[wr_idx] <= '{valid: wr_valid, ip: wr_ip, mac: wr_mac};
      end
   end

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_flat
      assign entries_flat[g*ENTRY_WIDTH +: ENTRY_WIDTH] = entries[g];
   end

endmodule

// File: rtl/arp_table_lookup.sv
// rtl/arp_table_lookup.sv - ARP responder: next-hop IPv4 to MAC lookup with valid/ready response.
// ARP_TABLE_PARALLEL_EN selects a single-cycle priority search instead of one entry per cycle.
module arp_table_lookup
   import arp_table_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_ENTRIES        = 32,
   parameter int IDX_WIDTH          = 5
) (
   input  logic                          AXI_ACLK,
   input  logic                          AXI_RESET,
   input  logic                          lookup_req,
   input  logic [31:0]                   lookup_ip,
   input  logic [7:0]                    lookup_oq,
   output logic                          lookup_ready,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic                          arp_hit,
   output logic [47:0]                   dest_mac,
   output logic [31:0]                   oq_reg,
   input  logic                          tbl_wr_en,
   input  logic [IDX_WIDTH-1:0]          tbl_wr_idx,
   input  logic [31:0]                   tbl_wr_ip,
   input  logic [31:0]                   tbl_wr_mac_low,
   input  logic [31:0]                   tbl_wr_mac_high,
   input  logic                          tbl_wr_valid,
   input  logic                          clear_counters,
   output logic [C_S_AXI_DATA_WIDTH-1:0] lookup_count,
   output logic [C_S_AXI_DATA_WIDTH-1:0] arp_miss_count
);

   state_t                           state;
   logic [IP_WIDTH-1:0]              cap_ip;
   logic [NUM_ENTRIES*ENTRY_WIDTH-1:0] entries_flat;
   arp_entry_t                       tbl [NUM_ENTRIES];
   logic                             search_done;
   logic                             search_hit;
   logic [MAC_WIDTH-1:0]             search_mac;
   logic                             accept;
   logic                             miss_done;
   logic                             unused_mac_high;

   assign unused_mac_high = ^tbl_wr_mac_high[31:16];

   arp_table_mem #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_WIDTH   (IDX_WIDTH)
   ) u_mem (
      .clk          (AXI_ACLK),
      .rst          (AXI_RESET),
      .wr_en        (tbl_wr_en),
      .wr_idx       (tbl_wr_idx),
      .wr_ip        (tbl_wr_ip),
      .wr_mac       ({tbl_wr_mac_high[15:0], tbl_wr_mac_low}),
      .wr_valid     (tbl_wr_valid),
      .entries_flat (entries_flat)
   );

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_unpack
      assign tbl[g] = entries_flat[g*ENTRY_WIDTH +: ENTRY_WIDTH];
   end

`ifdef ARP_TABLE_PARALLEL_EN
   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      search_hit  = 1'b0;
      search_mac  = '0;
      search_done = 1'b1;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (tbl[i].valid && (tbl[i].ip == cap_ip)) begin
            search_hit = 1'b1;
            search_mac = tbl[i].mac;
         end
      end
   end
`else
   logic [IDX_WIDTH-1:0] idx;
   arp_entry_t           cur;

   assign cur         = tbl[idx];
   assign search_hit  = cur.valid && (cur.ip == cap_ip);
   assign search_mac  = cur.mac;
   assign search_done = search_hit || (idx == IDX_WIDTH'(NUM_ENTRIES - 1));
`endif

   assign accept    = lookup_req && lookup_ready;
   assign miss_done = (state == SEARCH) && search_done && !search_hit;

   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         state        <= IDLE;
         cap_ip       <= '0;
         oq_reg       <= '0;
         arp_hit      <= 1'b0;
         dest_mac     <= '0;
         rsp_valid    <= 1'b0;
         lookup_ready <= 1'b1;
`ifndef ARP_TABLE_PARALLEL_EN
         idx          <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (lookup_req) begin
                  cap_ip       <= lookup_ip;
                  oq_reg       <= {24'b0, lookup_oq};
                  lookup_ready <= 1'b0;
                  state        <= SEARCH;
`ifndef ARP_TABLE_PARALLEL_EN
                  idx          <= '0;
`endif
               end
            end
            SEARCH: begin
               if (search_done) begin
                  arp_hit   <= search_hit;
                  dest_mac  <= search_hit ? search_mac : '0;
                  rsp_valid <= 1'b1;
                  state     <= RESPOND;
               end
`ifndef ARP_TABLE_PARALLEL_EN
               else begin
                  idx <= idx + 1'b1;
               end
`endif
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid    <= 1'b0;
                  lookup_ready <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               rsp_valid    <= 1'b0;
               lookup_ready <= 1'b1;
               state        <= IDLE;
            end
         endcase
      end
   end

   // Clear wins over an increment landing on the same edge.
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         lookup_count   <= '0;
         arp_miss_count <= '0;
      end else if (clear_counters) begin
         lookup_count   <= '0;
         arp_miss_count <= '0;
      end else begin
         if (accept) begin
            lookup_count <= lookup_count + 1'b1;
         end
         if (miss_done) begin
            arp_miss_count <= arp_miss_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_arp_table_lookup.sv
// tb/tb_arp_table_lookup.sv - directed self-checking bench for arp_table_lookup.
module tb_arp_table_lookup;

   logic        AXI_ACLK = 1'b0;
   logic        AXI_RESET;
   logic        lookup_req;
   logic [31:0] lookup_ip;
   logic [7:0]  lookup_oq;
   logic        lookup_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        arp_hit;
   logic [47:0] dest_mac;
   logic [31:0] oq_reg;
   logic        tbl_wr_en;
   logic [4:0]  tbl_wr_idx;
   logic [31:0] tbl_wr_ip;
   logic [31:0] tbl_wr_mac_low;
   logic [31:0] tbl_wr_mac_high;
   logic        tbl_wr_valid;
   logic        clear_counters;
   logic [31:0] lookup_count;
   logic [31:0] arp_miss_count;

   logic        unused_n_lookup_ready;
   logic        unused_n_rsp_valid;
   logic        unused_n_arp_hit;
   logic [47:0] unused_n_dest_mac;
   logic [31:0] unused_n_oq_reg;
   logic [1:0]  unused_n_lookup_count;
   logic [1:0]  n_arp_miss_count;

   int passed = 0;
   int total  = 0;
   int lat;

   always #5 AXI_ACLK = ~AXI_ACLK;

   arp_table_lookup dut (
      .AXI_ACLK        (AXI_ACLK),
      .AXI_RESET       (AXI_RESET),
      .lookup_req      (lookup_req),
      .lookup_ip       (lookup_ip),
      .lookup_oq       (lookup_oq),
      .lookup_ready    (lookup_ready),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .arp_hit         (arp_hit),
      .dest_mac        (dest_mac),
      .oq_reg          (oq_reg),
      .tbl_wr_en       (tbl_wr_en),
      .tbl_wr_idx      (tbl_wr_idx),
      .tbl_wr_ip       (tbl_wr_ip),
      .tbl_wr_mac_low  (tbl_wr_mac_low),
      .tbl_wr_mac_high (tbl_wr_mac_high),
      .tbl_wr_valid    (tbl_wr_valid),
      .clear_counters  (clear_counters),
      .lookup_count    (lookup_count),
      .arp_miss_count  (arp_miss_count)
   );

   // Narrow-counter copy: wraps after four misses instead of 2^32.
   arp_table_lookup #(.C_S_AXI_DATA_WIDTH(2)) dut_n (
      .AXI_ACLK        (AXI_ACLK),
      .AXI_RESET       (AXI_RESET),
      .lookup_req      (lookup_req),
      .lookup_ip       (lookup_ip),
      .lookup_oq       (lookup_oq),
      .lookup_ready    (unused_n_lookup_ready),
      .rsp_valid       (unused_n_rsp_valid),
      .rsp_ready       (rsp_ready),
      .arp_hit         (unused_n_arp_hit),
      .dest_mac        (unused_n_dest_mac),
      .oq_reg          (unused_n_oq_reg),
      .tbl_wr_en       (tbl_wr_en),
      .tbl_wr_idx      (tbl_wr_idx),
      .tbl_wr_ip       (tbl_wr_ip),
      .tbl_wr_mac_low  (tbl_wr_mac_low),
      .tbl_wr_mac_high (tbl_wr_mac_high),
      .tbl_wr_valid    (tbl_wr_valid),
      .clear_counters  (clear_counters),
      .lookup_count    (unused_n_lookup_count),
      .arp_miss_count  (n_arp_miss_count)
   );

   function automatic int exp_lat(input int k);
`ifdef ARP_TABLE_PARALLEL_EN
      return (k >= 0) ? 2 : 2;
`else
      return k + 2;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge AXI_ACLK);
      #1;
   endtask

   task automatic write_entry(input logic [4:0] idx, input logic [31:0] ip,
                              input logic [47:0] mac, input logic valid);
      tbl_wr_en       = 1'b1;
      tbl_wr_idx      = idx;
      tbl_wr_ip       = ip;
      tbl_wr_mac_low  = mac[31:0];
      tbl_wr_mac_high = {16'hDEAD, mac[47:32]};
      tbl_wr_valid    = valid;
      step();
      tbl_wr_en       = 1'b0;
   endtask

   task automatic start_lookup(input logic [31:0] ip, input logic [7:0] oq);
      lookup_req = 1'b1;
      lookup_ip  = ip;
      lookup_oq  = oq;
      step();
      lookup_req = 1'b0;
   endtask

   // Latency is reported as the edge at which rsp_valid is first sampled high, counted from acceptance.
   task automatic wait_rsp(input int n0, output int l);
      int n;
      n = n0;
      while (!rsp_valid && n < 100) begin
         step();
         n++;
      end
      l = n + 1;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      AXI_RESET = 1'b1;
      lookup_req = 1'b0; lookup_ip = '0; lookup_oq = '0; rsp_ready = 1'b0;
      tbl_wr_en = 1'b0; tbl_wr_idx = '0; tbl_wr_ip = '0; tbl_wr_mac_low = '0;
      tbl_wr_mac_high = '0; tbl_wr_valid = 1'b0; clear_counters = 1'b0;
      repeat (3) step();
      AXI_RESET = 1'b0;
      step();

      chk("rst_lookup_ready", lookup_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_arp_hit", arp_hit, 0);
      chk("rst_dest_mac", dest_mac, 0);
      chk("rst_oq_reg", oq_reg, 0);
      chk("rst_lookup_count", lookup_count, 0);
      chk("rst_miss_count", arp_miss_count, 0);

      // Hit at idx 3
      write_entry(5'd3, 32'h0A000105, 48'h001122334455, 1'b1);
      start_lookup(32'h0A000105, 8'h04);
      wait_rsp(0, lat);
      chk("hit3_latency", lat, exp_lat(3));
      chk("hit3_arp_hit", arp_hit, 1);
      chk("hit3_dest_mac", dest_mac, 48'h001122334455);
      chk("hit3_oq_reg", oq_reg, 32'h00000004);
      chk("hit3_lookup_count", lookup_count, 1);

      // Back-pressure: response held, new request ignored
      lookup_req = 1'b1;
      lookup_ip  = 32'h0A0001FF;
      lookup_oq  = 8'h80;
      repeat (10) step();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_lookup_ready", lookup_ready, 0);
      chk("hold_arp_hit", arp_hit, 1);
      chk("hold_dest_mac", dest_mac, 48'h001122334455);
      chk("hold_oq_reg", oq_reg, 32'h00000004);
      chk("hold_lookup_count", lookup_count, 1);
      lookup_req = 1'b0;
      finish_rsp();
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_lookup_ready", lookup_ready, 1);

      // Full miss
      start_lookup(32'h0A0001FF, 8'h01);
      wait_rsp(0, lat);
      chk("miss_latency", lat, exp_lat(31));
      chk("miss_arp_hit", arp_hit, 0);
      chk("miss_dest_mac", dest_mac, 0);
      chk("miss_oq_reg", oq_reg, 32'h00000001);
      chk("miss_count", arp_miss_count, 1);
      chk("miss_lookup_count", lookup_count, 2);
      finish_rsp();

      // Duplicate IPs: lowest index wins
      write_entry(5'd2, 32'hC0A80001, 48'hAAAAAAAA0002, 1'b1);
      write_entry(5'd7, 32'hC0A80001, 48'hBBBBBBBB0007, 1'b1);
      start_lookup(32'hC0A80001, 8'h02);
      wait_rsp(0, lat);
      chk("dup_latency", lat, exp_lat(2));
      chk("dup_dest_mac", dest_mac, 48'hAAAAAAAA0002);
      finish_rsp();

      // Invalidate entry 2 while idx 0 is being compared
      start_lookup(32'hC0A80001, 8'h02);
      write_entry(5'd2, 32'hC0A80001, 48'hAAAAAAAA0002, 1'b0);
      wait_rsp(1, lat);
`ifdef ARP_TABLE_PARALLEL_EN
      chk("inval_latency", lat, 2);
      chk("inval_dest_mac", dest_mac, 48'hAAAAAAAA0002);
`else
      chk("inval_latency", lat, 9);
      chk("inval_dest_mac", dest_mac, 48'hBBBBBBBB0007);
`endif
      chk("inval_arp_hit", arp_hit, 1);
      chk("inval_lookup_count", lookup_count, 4);
      finish_rsp();

      // Clear on the same edge the miss completes
      start_lookup(32'h01020304, 8'h10);
      repeat (exp_lat(31) - 2) step();
      clear_counters = 1'b1;
      step();
      clear_counters = 1'b0;
      chk("clr_rsp_valid", rsp_valid, 1);
      chk("clr_miss_count", arp_miss_count, 0);
      chk("clr_lookup_count", lookup_count, 0);
      finish_rsp();

      // Counter wrap on the 2-bit copy
      for (int i = 1; i <= 4; i++) begin
         start_lookup(32'h0B000000 + i, 8'h01);
         wait_rsp(0, lat);
         finish_rsp();
         if (i == 3) chk("wrap_narrow_at_max", n_arp_miss_count, 2'd3);
      end
      chk("wrap_narrow_zero", n_arp_miss_count, 2'd0);
      chk("wrap_full_count", arp_miss_count, 4);

      // Reset during SEARCH
      start_lookup(32'h0A000105, 8'h04);
      AXI_RESET = 1'b1;
      repeat (2) step();
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_lookup_ready", lookup_ready, 1);
      chk("midrst_lookup_count", lookup_count, 0);
      AXI_RESET = 1'b0;
      repeat (3) step();
      chk("midrst_no_rsp", rsp_valid, 0);
      start_lookup(32'h0A000105, 8'h04);
      wait_rsp(0, lat);
      chk("postrst_latency", lat, exp_lat(31));
      chk("postrst_arp_hit", arp_hit, 0);
      chk("postrst_miss_count", arp_miss_count, 1);
      finish_rsp();

      // Hit at the last index
      write_entry(5'd31, 32'h08080808, 48'h0A0B0C0D0E0F, 1'b1);
      start_lookup(32'h08080808, 8'h20);
      wait_rsp(0, lat);
      chk("hit31_latency", lat, exp_lat(31));
      chk("hit31_arp_hit", arp_hit, 1);
      chk("hit31_dest_mac", dest_mac, 48'h0A0B0C0D0E0F);
      chk("hit31_oq_reg", oq_reg, 32'h00000020);
      chk("hit31_miss_count", arp_miss_count, 1);
      chk("hit31_lookup_count", lookup_count, 2);
      finish_rsp();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
